uart_prog_loader: RTL and testbench
===================================

Name: uart_prog_loader

Overview:
- Host-to-target program loader: receives a framed program image on the UART rx line and writes it word by word into instruction memory.
- Sits in front of the pipeline, alongside the debug unit. The debug unit reads state out over tx; this block writes state in over rx.
- `done` gates the pipeline: the PC and pipeline enables are held until the image is loaded and verified.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (434 = 50 MHz / 115200 baud); minimum 4.
- ADDR_WIDTH, 10, instruction memory word-address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx  in  1  UART serial input, idle high, asynchronous to clk
- imem_we  out  1  one-cycle write strobe to instruction memory
- imem_addr  out  ADDR_WIDTH  word address for imem_we
- imem_wdata  out  32  word data for imem_we
- busy  out  1  high while a frame is in progress (length received, checksum not yet checked)
- done  out  1  image loaded and checksum good; sticky until reset
- error  out  1  framing, length or checksum error; sticky until the next frame start

Behaviour:

Reset:
- All outputs 0.
- FSM enters LEN_HI; byte and word counters 0; checksum 0.
- The rx synchronizer is preset to 1.
- Reset mid-frame aborts the frame and discards partial data. Words already written stay in memory but are not valid.

UART receive (8N1, LSB first):
- rx passes through a 2-flop synchronizer.
- Start detect: falling edge of the synchronized rx.
- Re-sample at CLKS_PER_BIT/2. If rx is high, treat it as a glitch and return to idle.
- Sample each of the 8 data bits at 1×CLKS_PER_BIT intervals from that point.
- Stop bit:
  - Sampled 1: the byte is valid and `byte_valid` pulses for one cycle.
  - Sampled 0: framing error. The byte is dropped, error is set, and the FSM goes to LEN_HI.
- The receiver waits for rx high before arming the next start detect.

Frame format (all bytes MSB-first within multi-byte fields):
- LEN_HI, LEN_LO: 16-bit word count N.
- N words of 4 bytes each.
- One checksum byte, equal to the XOR of every preceding byte in the frame.

FSM states and transitions (advance on `byte_valid`):
- LEN_HI:
  - Clears error.
  - Clears the checksum, then XORs in this byte.
  - Stores the byte as N[15:8] and sets busy.
  - Goes to LEN_LO.
- LEN_LO:
  - Stores N[7:0].
  - If N > 2^ADDR_WIDTH: set error, clear busy, go to LEN_HI.
  - Else if N = 0: go to CHK.
  - Else: go to WORD, with word counter 0 and byte counter 0.
- WORD:
  - Shifts each byte into a 32-bit assembly register and increments the byte counter.
  - On the 4th byte, on the following cycle:
    - imem_we = 1 for exactly one cycle;
    - imem_addr = word counter;
    - imem_wdata = the assembled word.
  - Then the word counter increments and the byte counter returns to 0.
  - After word N-1 is written, go to CHK.
- CHK:
  - Received byte equals the checksum: done = 1, busy = 0, go to DONE.
  - Otherwise: error = 1, busy = 0, go to LEN_HI.
- DONE:
  - Terminal state; all further rx bytes are ignored.
  - Only reset leaves this state.

Width and timing rules:
- Checksum: 8-bit XOR.
- imem_addr and imem_wdata hold their last values when imem_we = 0.
- Latency: imem_we asserts 1 clk after the `byte_valid` of the word's 4th byte.
- The maximum address written is N-1, so there is no wrap-around.

Test Plan:
- CLKS_PER_BIT=4, ADDR_WIDTH=4:
  - Send frame 00 02 | 12 34 56 78 | 9A BC DE F0 | chk = 0x02 (XOR of all ten bytes).
  - Expect exactly two imem_we pulses: addr 0 / 0x12345678, then addr 1 / 0x9ABCDEF0.
  - Expect done = 1, error = 0, busy = 0 afterwards.
- Send a frame with N = 0 and checksum 00 -> no writes; done = 1.
- Send N = 1, word 0xDEADBEEF, wrong checksum 0xFF -> one write; done = 0, error = 1.
  - Then send a correct N = 1 frame -> error clears on its LEN_HI byte; done = 1.
- Send N = 0x0011 (17 > 16) -> error = 1 after LEN_LO; no writes; FSM back in LEN_HI.
- Framing and glitch errors:
  - Send a byte with the stop bit driven 0 in the middle of a word -> error = 1; that byte is not written.
  - Pulse rx low for 1 clk only -> no byte is detected.
- Assert reset after 2 of 4 bytes of a word -> all outputs 0.
  - A subsequent full valid frame loads correctly and sets done.
  - After done, further rx bytes cause no imem_we.

Source files
------------

// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Receives a framed program image over a UART rx line (8N1, LSB first)
//   and writes it word by word into instruction memory.
//   Frame: LEN_HI LEN_LO | N x 4-byte words (MSB first) | XOR checksum byte.
//   done gates the pipeline; it rises only after the checksum verifies.
// Ports:
//   clk_i         system clock
//   reset_i       synchronous active-high reset
//   rx_i          UART serial input, idle high, asynchronous to clk_i
//   imem_we_o     one-cycle instruction memory write strobe
//   imem_addr_o   word address for imem_we_o (held between strobes)
//   imem_wdata_o  word data for imem_we_o (held between strobes)
//   busy_o        frame in progress (length received, checksum pending)
//   done_o        image loaded and verified; sticky until reset
//   error_o       framing/length/checksum error; cleared by next frame start
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  rx_i,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_wdata_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);
    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [16:0]   MAX_LEN = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_st_e;
    typedef enum logic [2:0] {LEN_HI, LEN_LO, WORD, CHK, DONE} fr_st_e;

    // rx synchronizer plus one history flop for falling-edge detect
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    rx_st_e          rs_q, rs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic            byte_valid, frame_err;

    fr_st_e                fs_q, fs_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           wcnt_q, wcnt_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            chk_q, chk_d;
    logic                  we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [15:0]           n_len;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            rs_q      <= R_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            fs_q      <= LEN_HI;
            len_q     <= '0;
            wcnt_q    <= '0;
            bcnt_q    <= '0;
            asm_q     <= '0;
            chk_q     <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            rs_q      <= rs_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            fs_q      <= fs_d;
            len_q     <= len_d;
            wcnt_q    <= wcnt_d;
            bcnt_q    <= bcnt_d;
            asm_q     <= asm_d;
            chk_q     <= chk_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // UART byte receiver
    always_comb begin
        rs_d       = rs_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        sh_d       = sh_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        case (rs_q)
            R_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rs_d = R_START;
            end
            R_START: if (cnt_q == HALF_M1) begin
                cnt_d = '0;
                bit_d = '0;
                // line back high at mid start bit: glitch, not a start
                rs_d  = rx_sync_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt_q == FULL_M1) begin
                cnt_d = '0;
                sh_d  = {rx_sync_q, sh_q[7:1]};
                bit_d = bit_q + 1'b1;
                if (bit_q == 3'd7) rs_d = R_STOP;
            end
            R_STOP: if (cnt_q == FULL_M1) begin
                cnt_d = '0;
                if (rx_sync_q) begin
                    byte_valid = 1'b1;
                    rs_d       = R_IDLE;
                end else begin
                    frame_err = 1'b1;
                    rs_d      = R_WAIT;
                end
            end
            R_WAIT: begin
                // re-arm only once the line has returned high
                cnt_d = '0;
                if (rx_sync_q) rs_d = R_IDLE;
            end
            default: rs_d = R_IDLE;
        endcase
    end

    // Frame parser / memory writer
    always_comb begin
        fs_d    = fs_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        chk_d   = chk_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        n_len   = {len_q[15:8], sh_q};
        if (byte_valid) begin
            case (fs_q)
                LEN_HI: begin
                    err_d       = 1'b0;
                    chk_d       = sh_q;
                    len_d[15:8] = sh_q;
                    busy_d      = 1'b1;
                    fs_d        = LEN_LO;
                end
                LEN_LO: begin
                    chk_d      = chk_q ^ sh_q;
                    len_d[7:0] = sh_q;
                    if ({1'b0, n_len} > MAX_LEN) begin
                        err_d  = 1'b1;
                        busy_d = 1'b0;
                        fs_d   = LEN_HI;
                    end else if (n_len == 16'd0) begin
                        fs_d = CHK;
                    end else begin
                        wcnt_d = '0;
                        bcnt_d = '0;
                        fs_d   = WORD;
                    end
                end
                WORD: begin
                    chk_d  = chk_q ^ sh_q;
                    asm_d  = {asm_q[15:0], sh_q};
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = wcnt_q[ADDR_WIDTH-1:0];
                        wdata_d = {asm_q, sh_q};
                        wcnt_d  = wcnt_q + 1'b1;
                        if (wcnt_q == len_q - 16'd1) fs_d = CHK;
                    end
                end
                CHK: begin
                    busy_d = 1'b0;
                    if (sh_q == chk_q) begin
                        done_d = 1'b1;
                        fs_d   = DONE;
                    end else begin
                        err_d = 1'b1;
                        fs_d  = LEN_HI;
                    end
                end
                default: ;  // DONE: ignore everything until reset
            endcase
        end else if (frame_err && fs_q != DONE) begin
            err_d  = 1'b1;
            busy_d = 1'b0;
            fs_d   = LEN_HI;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader at CLKS_PER_BIT=4, ADDR_WIDTH=4.
// Frames are table-driven; expected writes go to a scoreboard queue and are
// popped by a monitor on every imem_we strobe.
module tb_uart_prog_loader;
    localparam int CPB = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy, done, error;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        bit          rst;
        int          nb;
        logic [95:0] by;
        logic        e_done, e_err, e_busy;
    } vec_t;
    vec_t vecs[6];

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .reset_i(reset), .rx_i(rx),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
        .busy_o(busy), .done_o(done), .error_o(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, none expected", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (imem_addr !== e.a || imem_wdata !== e.d) begin
                    errors++;
                    $display("FAIL write: got %h/%h expected %h/%h", imem_addr, imem_wdata, e.a, e.d);
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk);
        rx = 1'b0;
        clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            clks(CPB);
        end
        rx = stop;
        clks(CPB);
        rx = 1'b1;
        clks(CPB);
    endtask

    task automatic do_reset();
        @(posedge clk);
        reset = 1'b1;
        clks(2);
        reset = 1'b0;
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        wr_t w;
        w.a = AW'(a);
        w.d = d;
        sb.push_back(w);
    endtask

    task automatic check_outs(input string tag, input logic e_done, input logic e_err, input logic e_busy);
        @(negedge clk);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, e_err});
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
    endtask

    task automatic check_sb_empty(input string tag);
        clks(4);
        @(negedge clk);
        chk({tag, "_pending_writes"}, sb.size(), 0);
        sb.delete();
    endtask

    // expected writes follow from the frame alone: N words if N fits memory
    task automatic apply_vec(input vec_t v, input int idx);
        logic [7:0]  b[12];
        logic [15:0] n;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        for (int i = 0; i < 12; i++) b[i] = v.by[95-8*i -: 8];
        n = {b[0], b[1]};
        if (v.rst) do_reset();
        if (n <= 16 && v.nb >= 2 + 4 * int'(n))
            for (int w = 0; w < int'(n); w++)
                push_wr(w, {b[2+4*w], b[3+4*w], b[4+4*w], b[5+4*w]});
        for (int i = 0; i < v.nb; i++) send_byte(b[i], 1'b1);
        check_outs(tag, v.e_done, v.e_err, v.e_busy);
        check_sb_empty(tag);
    endtask

    initial begin
        vecs[0] = '{1'b1, 11, {64'h0002_1234_5678_9ABC, 24'hDEF002, 8'h00}, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 3,  {24'h000000, 72'h0}, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 7,  {56'h0001_DEAD_BEEF_FF, 40'h0}, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 7,  {56'h0001_DEAD_BEEF_23, 40'h0}, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 2,  {16'h0011, 80'h0}, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 3,  {24'h000000, 72'h0}, 1'b1, 1'b0, 1'b0};

        clks(3);
        @(negedge clk);
        chk("rst_we", {31'd0, imem_we}, 0);
        chk("rst_addr", {28'd0, imem_addr}, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_error", {31'd0, error}, 0);
        reset = 1'b0;
        clks(2);

        for (int i = 0; i < 6; i++) apply_vec(vecs[i], i);

        // error clears on the LEN_HI byte of the next frame
        do_reset();
        push_wr(0, 32'hDEADBEEF);
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
        send_byte(8'hFF, 1'b1);
        check_outs("badchk", 1'b0, 1'b1, 1'b0);
        push_wr(0, 32'hDEADBEEF);
        send_byte(8'h00, 1'b1);
        check_outs("lenhi_clear", 1'b0, 1'b0, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
        send_byte(8'h23, 1'b1);
        check_outs("retry", 1'b1, 1'b0, 1'b0);
        check_sb_empty("retry");

        // framing error in the middle of a word: nothing written
        do_reset();
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1); send_byte(8'h78, 1'b0);
        check_outs("framing", 1'b0, 1'b1, 1'b0);
        check_sb_empty("framing");

        // one-clock low glitch is not a start bit
        do_reset();
        @(posedge clk); rx = 1'b0;
        @(posedge clk); rx = 1'b1;
        clks(60);
        check_outs("glitch", 1'b0, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        check_outs("glitch_after", 1'b1, 1'b0, 1'b0);
        check_sb_empty("glitch");

        // reset mid-word, then a clean frame, then bytes after done
        do_reset();
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
        @(posedge clk); reset = 1'b1;
        clks(2);
        @(negedge clk);
        chk("midrst_we", {31'd0, imem_we}, 0);
        chk("midrst_addr", {28'd0, imem_addr}, 0);
        chk("midrst_wdata", imem_wdata, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        chk("midrst_error", {31'd0, error}, 0);
        reset = 1'b0;
        clks(2);
        push_wr(0, 32'h11223344);
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
        send_byte(8'h45, 1'b1);
        check_outs("reload", 1'b1, 1'b0, 1'b0);
        check_sb_empty("reload");
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1); send_byte(8'h88, 1'b1);
        send_byte(8'h00, 1'b0);
        check_outs("after_done", 1'b1, 1'b0, 1'b0);
        check_sb_empty("after_done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
